// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit frame arbiter.
// Contents:
//   arb_state_t   - 3-bit FSM state encoding used by uart_tx_frame_arbiter
//   CRC8_POLY     - CRC8 generator polynomial x^8+x^2+x+1
//   TAIL_DEFAULT  - default frame tail byte
//   BYTE_IDX_LAST - index of the final byte (tail) of a frame
//   crc8_step     - one-byte CRC8 update, MSB first, no reflection
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        LOAD  = 3'd2,
        KICK  = 3'd3,
        WAIT  = 3'd4,
        GAP   = 3'd5,
        DONE  = 3'd6,
        ABORT = 3'd7
    } arb_state_t;

    localparam logic [7:0] CRC8_POLY     = 8'h07;
    localparam logic [7:0] TAIL_DEFAULT  = 8'h55;
    localparam logic [2:0] BYTE_IDX_LAST = 3'd5;

    // The byte is folded into the top of the register first, then shifted out
    // eight times; this is the usual byte-wise form of the bit-serial LFSR.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/crc8.sv
// CRC8 accumulator (poly 0x07, init 0x00, no reflection, no xor-out).
// Ports:
//   clk_50M  in  1  system clock
//   rst_n    in  1  asynchronous active-low reset
//   crc_en   in  1  fold data_in into the running CRC this cycle
//   crc_clr  in  1  restart the CRC at 0x00 (wins over crc_en)
//   data_in  in  8  byte to accumulate
//   crc_out  out 8  running CRC value
module crc8
    import uart_pkg::*;
(
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic       crc_en,
    input  logic       crc_clr,
    input  logic [7:0] data_in,
    output logic [7:0] crc_out
);

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            crc_out <= '0;
        end else if (crc_clr) begin
            crc_out <= '0;
        end else if (crc_en) begin
            crc_out <= crc8_step(crc_out, data_in);
        end
    end

endmodule

// File: rtl/uart_tx_frame_arbiter.sv
// Shares one uart_tx byte transmitter between two frame requesters with
// round-robin arbitration. Each granted frame is sent as:
//   header (HDR0/HDR1), payload b1, b2, b3, CRC8(b1..b3), TAIL
// Ports:
//   clk_50M       in   1   system clock
//   rst_n         in   1   asynchronous active-low reset
//   req           in   2   per-channel frame request (level)
//   payload0/1    in   24  {b1,b2,b3}, b1 sent first, sampled at grant
//   gnt           out  2   one-hot frame owner, 0 when idle
//   ack           out  2   1-cycle pulse on frame completion
//   err           out  2   1-cycle pulse on frame timeout abort
//   arb_busy      out  1   high from grant until ack/err
//   uart_tx_en    out  1   1-cycle start strobe to uart_tx
//   uart_tx_data  out  8   byte to uart_tx, held from kick until done
//   uart_tx_done  in   1   byte complete pulse from uart_tx
//   uart_tx_busy  in   1   uart_tx is shifting
module uart_tx_frame_arbiter
    import uart_pkg::*;
#(
    parameter logic [7:0]  HDR0       = 8'h80,
    parameter logic [7:0]  HDR1       = 8'h81,
    parameter logic [7:0]  TAIL       = TAIL_DEFAULT,
    parameter int unsigned GAP_CYCLES = 16,
    parameter logic [31:0] TIMEOUT    = 32'd100000
) (
    input  logic        clk_50M,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [23:0] payload0,
    input  logic [23:0] payload1,
    output logic [1:0]  gnt,
    output logic [1:0]  ack,
    output logic [1:0]  err,
    output logic        arb_busy,
    output logic        uart_tx_en,
    output logic [7:0]  uart_tx_data,
    input  logic        uart_tx_done,
    input  logic        uart_tx_busy
);

    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    arb_state_t  state, next_state;
    logic        owner;
    logic        rr_last;
    logic        winner;
    logic [23:0] shadow;
    logic [2:0]  byte_idx;
    logic [7:0]  gap_cnt;
    logic [31:0] timer;
    logic [7:0]  tx_byte;
    logic [7:0]  crc_out;
    logic        crc_en;
    logic        crc_clr;
    logic        gap_last;
    logic        timer_expired;

    // On a tie the channel that did not own the previous frame wins.
    assign winner        = (req == 2'b11) ? ~rr_last : req[1];
    assign gap_last      = (gap_cnt == GAP_LAST);
    assign timer_expired = (timer >= TIMEOUT - 32'd1);

    // Byte selected for the current position within the frame.
    always_comb begin
        tx_byte = TAIL;
        case (byte_idx)
            3'd0:    tx_byte = owner ? HDR1 : HDR0;
            3'd1:    tx_byte = shadow[23:16];
            3'd2:    tx_byte = shadow[15:8];
            3'd3:    tx_byte = shadow[7:0];
            3'd4:    tx_byte = crc_out;
            default: tx_byte = TAIL;
        endcase
    end

    crc8 u_crc8 (
        .clk_50M (clk_50M),
        .rst_n   (rst_n),
        .crc_en  (crc_en),
        .crc_clr (crc_clr),
        .data_in (tx_byte),
        .crc_out (crc_out)
    );

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state plus the CRC strobes, which are needed in the same cycle.
    always_comb begin
        next_state = state;
        crc_clr    = 1'b0;
        crc_en     = 1'b0;
        case (state)
            IDLE:  if (|req) next_state = GRANT;
            GRANT: begin
                crc_clr    = 1'b1;
                next_state = LOAD;
            end
            LOAD: begin
                crc_en     = (byte_idx >= 3'd1) && (byte_idx <= 3'd3);
                next_state = KICK;
            end
            KICK:  if (!uart_tx_busy) next_state = WAIT;
            WAIT: begin
                if (uart_tx_done) begin
                    next_state = GAP;
                end else if (timer_expired) begin
                    next_state = ABORT;
                end
            end
            GAP: begin
                if (gap_last) begin
                    next_state = (byte_idx == BYTE_IDX_LAST) ? DONE : LOAD;
                end
            end
            DONE:    next_state = IDLE;
            ABORT:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Registered outputs and frame datapath. The owner is fixed when IDLE
    // sees a request, so arbitration happens only on that transition.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            gnt          <= '0;
            ack          <= '0;
            err          <= '0;
            arb_busy     <= 1'b0;
            uart_tx_en   <= 1'b0;
            uart_tx_data <= '0;
            owner        <= 1'b0;
            rr_last      <= 1'b1;
            shadow       <= '0;
            byte_idx     <= '0;
            gap_cnt      <= '0;
            timer        <= '0;
        end else begin
            ack        <= '0;
            err        <= '0;
            uart_tx_en <= 1'b0;
            case (state)
                IDLE:  if (|req) owner <= winner;
                GRANT: begin
                    gnt      <= owner ? 2'b10 : 2'b01;
                    shadow   <= owner ? payload1 : payload0;
                    byte_idx <= '0;
                    arb_busy <= 1'b1;
                end
                LOAD:  uart_tx_data <= tx_byte;
                KICK: begin
                    if (!uart_tx_busy) begin
                        uart_tx_en <= 1'b1;
                        timer      <= '0;
                    end
                end
                WAIT: begin
                    if (uart_tx_done) begin
                        gap_cnt <= '0;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 8'd1;
                    if (gap_last && (byte_idx != BYTE_IDX_LAST)) begin
                        byte_idx <= byte_idx + 3'd1;
                    end
                end
                DONE: begin
                    ack[owner] <= 1'b1;
                    gnt        <= '0;
                    arb_busy   <= 1'b0;
                    rr_last    <= owner;
                end
                ABORT: begin
                    err[owner] <= 1'b1;
                    gnt        <= '0;
                    arb_busy   <= 1'b0;
                    rr_last    <= owner;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_arbiter.sv
// Self-checking bench for uart_tx_frame_arbiter with a behavioural uart_tx
// model and a frame-level reference model (byte map, CRC8, round-robin).
module tb_uart_tx_frame_arbiter;

    localparam int TIMEOUT_T    = 200;
    localparam int FRAME_BUDGET = 6000;

    logic        clk_50M = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [23:0] payload0 = '0;
    logic [23:0] payload1 = '0;
    logic [1:0]  gnt, ack, err;
    logic        arb_busy, uart_tx_en;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_done;
    logic        uart_tx_busy;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          byte_clks = 100;
    bit          never_done = 1'b0;
    bit          hold_req = 1'b0;
    logic        model_rr = 1'b1;
    int          ack_cnt = 0;
    int          err_cnt = 0;
    logic [7:0]  cap_data[$];
    logic [1:0]  cap_gnt[$];

    uart_tx_frame_arbiter #(
        .GAP_CYCLES (16),
        .TIMEOUT    (32'(TIMEOUT_T))
    ) dut (
        .clk_50M      (clk_50M),
        .rst_n        (rst_n),
        .req          (req),
        .payload0     (payload0),
        .payload1     (payload1),
        .gnt          (gnt),
        .ack          (ack),
        .err          (err),
        .arb_busy     (arb_busy),
        .uart_tx_en   (uart_tx_en),
        .uart_tx_data (uart_tx_data),
        .uart_tx_done (uart_tx_done),
        .uart_tx_busy (uart_tx_busy)
    );

    always #10 clk_50M = ~clk_50M;

    // Behavioural uart_tx: a kick makes it busy for byte_clks cycles, then it
    // pulses done for one cycle. In never_done mode it swallows the kick.
    initial begin
        uart_tx_busy = 1'b0;
        uart_tx_done = 1'b0;
        forever begin
            @(negedge clk_50M);
            uart_tx_done = 1'b0;
            if (uart_tx_en && !never_done) begin
                uart_tx_busy = 1'b1;
                repeat (byte_clks - 1) @(negedge clk_50M);
                uart_tx_busy = 1'b0;
                uart_tx_done = 1'b1;
            end
        end
    end

    initial begin
        #3ms;
        $display("[TB] FAIL watchdog: simulation ran too long");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] refCrc8(input logic [23:0] data);
        logic [7:0] crc;
        logic       fb;
        crc = 8'h00;
        for (int i = 23; i >= 0; i--) begin
            fb  = crc[7] ^ data[i];
            crc = {crc[6:0], 1'b0};
            if (fb) crc = crc ^ 8'h07;
        end
        return crc;
    endfunction

    function automatic logic [7:0] expByte(input int owner, input logic [23:0] pl, input int idx);
        case (idx)
            0:       return (owner == 1) ? 8'h81 : 8'h80;
            1:       return pl[23:16];
            2:       return pl[15:8];
            3:       return pl[7:0];
            4:       return refCrc8(pl);
            default: return 8'h55;
        endcase
    endfunction

    function automatic int pickOwner(input logic [1:0] pend, input logic last);
        if (pend == 2'b11) return last ? 0 : 1;
        return pend[0] ? 0 : 1;
    endfunction

    // One clock step: observe kicks and pulses, and play the requesters,
    // which drop their request on the matching ack/err unless holding.
    task automatic tick();
        @(negedge clk_50M);
        if (rst_n) begin
            if (uart_tx_en) begin
                cap_data.push_back(uart_tx_data);
                cap_gnt.push_back(gnt);
            end
            if (ack != 2'b00) ack_cnt++;
            if (err != 2'b00) err_cnt++;
            if (!hold_req) req = req & ~(ack | err);
        end
    endtask

    task automatic resetDut();
        rst_n      = 1'b0;
        req        = 2'b00;
        hold_req   = 1'b0;
        never_done = 1'b0;
        byte_clks  = 100;
        repeat (3) @(negedge clk_50M);
        cap_data.delete();
        cap_gnt.delete();
        ack_cnt  = 0;
        err_cnt  = 0;
        model_rr = 1'b1;
        rst_n    = 1'b1;
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic [23:0] p0, input logic [23:0] p1);
        repeat (2) tick();
        payload0 = p0;
        payload1 = p1;
        req      = r;
    endtask

    // Wait for a frame owned by 'owner' to finish and compare all six bytes.
    task automatic expectFrame(input int owner, input logic [23:0] pl);
        int cyc;
        cyc = 0;
        while (gnt == 2'b00 && cyc < FRAME_BUDGET) begin
            tick();
            cyc++;
        end
        checkOutput("gnt_owner", 32'(gnt), 32'(1 << owner));
        checkOutput("busy_in_frame", 32'(arb_busy), 32'd1);
        cyc = 0;
        while (ack == 2'b00 && err == 2'b00 && cyc < FRAME_BUDGET) begin
            tick();
            cyc++;
        end
        checkOutput("ack_owner", 32'(ack), 32'(1 << owner));
        checkOutput("gnt_released", {30'd0, gnt}, 32'd0);
        checkOutput("busy_released", 32'(arb_busy), 32'd0);
        checkOutput("byte_count", 32'(cap_data.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < cap_data.size()) begin
                checkOutput($sformatf("byte%0d", i), 32'(cap_data[i]), 32'(expByte(owner, pl, i)));
                checkOutput($sformatf("byte%0d_gnt", i), 32'(cap_gnt[i]), 32'(1 << owner));
            end
        end
        cap_data.delete();
        cap_gnt.delete();
        model_rr = owner[0];
    endtask

    initial begin
        int          cyc;
        int          own;
        logic [1:0]  pend;
        logic [23:0] p0, p1;

        // Reset state
        resetDut();
        tick();
        checkOutput("reset_outputs", {20'd0, gnt, ack, err, arb_busy, uart_tx_en, 2'd0},
                    32'd0);
        checkOutput("reset_data", 32'(uart_tx_data), 32'd0);

        // Single ch0 frame with the reference payload and latency checks
        applyStimulus(2'b01, 24'h123456, 24'h0);
        cyc = 0;
        while (gnt == 2'b00 && cyc < 20) begin tick(); cyc++; end
        checkOutput("gnt_latency", 32'(cyc), 32'd2);
        while (!uart_tx_en && cyc < 20) begin tick(); cyc++; end
        checkOutput("kick_latency", 32'(cyc), 32'd4);
        expectFrame(0, 24'h123456);
        repeat (60) tick();
        checkOutput("ack_once", 32'(ack_cnt), 32'd1);

        // Simultaneous requests after reset: ch0 first, then ch1
        resetDut();
        p0 = 24'($urandom);
        p1 = 24'($urandom);
        applyStimulus(2'b11, p0, p1);
        pend = 2'b11;
        while (pend != 2'b00) begin
            own = pickOwner(pend, model_rr);
            expectFrame(own, own ? p1 : p0);
            pend[own] = 1'b0;
        end
        checkOutput("tie_ack_count", 32'(ack_cnt), 32'd2);

        // Both requests held: grants alternate over four frames
        resetDut();
        hold_req = 1'b1;
        p0 = 24'($urandom);
        p1 = 24'($urandom);
        applyStimulus(2'b11, p0, p1);
        for (int f = 0; f < 4; f++) begin
            own = pickOwner(2'b11, model_rr);
            expectFrame(own, own ? p1 : p0);
        end

        // Timeout abort, then the pending ch1 request is served
        resetDut();
        never_done = 1'b1;
        p0 = 24'($urandom);
        p1 = 24'($urandom);
        applyStimulus(2'b01, p0, p1);
        cyc = 0;
        while (!uart_tx_en && cyc < 50) begin tick(); cyc++; end
        req[1] = 1'b1;
        cyc = 0;
        while (err == 2'b00 && cyc < TIMEOUT_T + 50) begin tick(); cyc++; end
        checkOutput("abort_err", 32'(err), 32'd1);
        checkOutput("abort_time_in_window", 32'((cyc >= TIMEOUT_T) && (cyc <= TIMEOUT_T + 2)), 32'd1);
        checkOutput("abort_gnt", {30'd0, gnt}, 32'd0);
        checkOutput("abort_no_ack", 32'(ack_cnt), 32'd0);
        never_done = 1'b0;
        cap_data.delete();
        cap_gnt.delete();
        model_rr = 1'b0;
        expectFrame(1, p1);

        // Payload change and request drop mid-frame
        resetDut();
        p0 = 24'($urandom);
        applyStimulus(2'b01, p0, 24'h0);
        cyc = 0;
        while (cap_data.size() < 3 && cyc < FRAME_BUDGET) begin tick(); cyc++; end
        payload0 = ~p0;
        req[0]   = 1'b0;
        expectFrame(0, p0);
        repeat (30) tick();
        checkOutput("no_regrant", {30'd0, gnt}, 32'd0);

        // Asynchronous reset during byte 3, then a clean frame
        resetDut();
        p0 = 24'($urandom);
        applyStimulus(2'b01, p0, 24'h0);
        cyc = 0;
        while (cap_data.size() < 4 && cyc < FRAME_BUDGET) begin tick(); cyc++; end
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_outputs", {20'd0, gnt, ack, err, arb_busy, uart_tx_en, 2'd0},
                    32'd0);
        req = 2'b00;
        repeat (5) tick();
        checkOutput("reset_no_ack_err", 32'(ack_cnt + err_cnt), 32'd0);
        cap_data.delete();
        cap_gnt.delete();
        model_rr = 1'b1;
        @(negedge clk_50M);
        rst_n = 1'b1;
        p0 = 24'($urandom);
        applyStimulus(2'b01, p0, 24'h0);
        expectFrame(0, p0);

        // Randomised request patterns, payloads and uart speeds
        resetDut();
        for (int it = 0; it < 6; it++) begin
            byte_clks = int'($urandom_range(20, 60));
            pend = 2'($urandom_range(1, 3));
            p0 = 24'($urandom);
            p1 = 24'($urandom);
            applyStimulus(pend, p0, p1);
            while (pend != 2'b00) begin
                own = pickOwner(pend, model_rr);
                expectFrame(own, own ? p1 : p0);
                pend[own] = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
